// File: rtl/div_root_pkg.sv
`default_nettype none
// ============================================================================
// div_root_pkg : shared Q-format widths and FSM states for divider / sqrt
// Revision     : 1.0
// ============================================================================
package div_root_pkg;

    localparam int IN_W   = 20;
    localparam int FRAC_W = 10;
    localparam int OUT_W  = (IN_W + FRAC_W) / 2;
    localparam int RAD_W  = IN_W + FRAC_W;

    localparam logic [OUT_W-1:0] TRIAL_START = OUT_W'(1) << (OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_trial.sv
`default_nettype none
// ============================================================================
// sqrt_trial : one guess-and-check step, T = result|trial, compare T*T to R
// Revision   : 1.0
// ============================================================================
module sqrt_trial
    import div_root_pkg::*;
#(
    parameter int W = OUT_W
) (
    input  logic [W-1:0]   result,
    input  logic [W-1:0]   trial,
    input  logic [2*W-1:0] radicand,
    output logic [W-1:0]   trial_val,
    output logic           lt,
    output logic           eq
);

    logic [2*W-1:0] w_square;

    // The only multiplier in the stage; kept here so it can be pipelined alone.
    always_comb begin
        trial_val = result | trial;
        w_square  = (2*W)'(trial_val) * (2*W)'(trial_val);
        lt        = (w_square < radicand);
        eq        = (w_square == radicand);
    end

endmodule
`default_nettype wire

// File: rtl/sqrt_stage.sv
`default_nettype none
// ============================================================================
// sqrt_stage : bit-serial Q10.10 -> Q5.10 square root, early exit on exact hit
// Revision   : 1.0
// ============================================================================
module sqrt_stage
    import div_root_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_exact
);

    state_t           r_state;
    logic [RAD_W-1:0] r_rad;
    logic [OUT_W-1:0] r_result;
    logic [OUT_W-1:0] r_trial;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_exact;

    logic [OUT_W-1:0] w_t;
    logic             w_lt;
    logic             w_eq;

    sqrt_trial #(
        .W (OUT_W)
    ) u_trial (
        .result    (r_result),
        .trial     (r_trial),
        .radicand  (r_rad),
        .trial_val (w_t),
        .lt        (w_lt),
        .eq        (w_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rad       <= '0;
            r_result    <= '0;
            r_trial     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_exact     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_rad      <= {in_data, {FRAC_W{1'b0}}};
                        r_trial    <= TRIAL_START;
                        r_result   <= '0;
                        // A zero radicand never produces an exact hit in CALC.
                        r_exact    <= (in_data == '0);
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    if (w_lt || w_eq)
                        r_result <= w_t;
                    r_trial <= r_trial >> 1;
                    if (w_eq) begin
                        r_exact     <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_trial[0]) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_result;
    assign out_exact = r_exact;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_stage.sv
`default_nettype none
// ============================================================================
// tb_sqrt_stage : directed self-checking bench for sqrt_stage
// Revision      : 1.0
// ============================================================================
module tb_sqrt_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [19:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [14:0] out_data;
    logic        out_exact;

    int checks = 0;
    int errors = 0;

    sqrt_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_exact (out_exact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start(input logic [19:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    // k0 = cycles already elapsed since accept; returns in the in_ready-rising cycle.
    task automatic wait_result(input string tag, input int k0, input logic [14:0] exp_d,
                               input logic exp_x, input int exp_lat);
        int k;
        k = k0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid"},   32'(out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(k),         32'(exp_lat));
        chk({tag, "_data"},    32'(out_data),  32'(exp_d));
        chk({tag, "_exact"},   32'(out_exact), 32'(exp_x));
        @(negedge clk);
        chk({tag, "_pulse"},   32'(out_valid), 32'd0);
        chk({tag, "_ready"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_exact", 32'(out_exact), 32'd0);

        start(20'h00400);
        chk("busy_ready", 32'(in_ready), 32'd0);
        wait_result("one", 0, 15'h0400, 1'b1, 5);

        start(20'h00800);
        wait_result("two", 0, 15'h05A8, 1'b0, 15);

        start(20'hFFFFF);
        wait_result("max", 0, 15'h7FFF, 1'b0, 15);

        start(20'h00000);
        wait_result("zero", 0, 15'h0000, 1'b1, 15);
        repeat (3) @(negedge clk);
        chk("hold_data",  32'(out_data),  32'd0);
        chk("hold_exact", 32'(out_exact), 32'd1);
        chk("hold_valid", 32'(out_valid), 32'd0);

        // Input offered mid-computation must be dropped.
        start(20'h00800);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 20'h01000;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("ignored", 2, 15'h05A8, 1'b0, 15);
        start(20'h01000);
        wait_result("b2b", 0, 15'h0800, 1'b1, 4);

        // Reset sampled at E7 of a running job.
        start(20'h00800);
        repeat (6) @(negedge clk);
        chk("pre_rst_data", 32'(out_data), 32'h400);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ready", 32'(in_ready),  32'd1);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data",  32'(out_data),  32'd0);
        chk("mrst_exact", 32'(out_exact), 32'd0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("mrst_no_valid", 32'(pulses), 32'd0);
        start(20'h00400);
        wait_result("post_rst", 0, 15'h0400, 1'b1, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
